gc_apb_poller: RTL and testbench

- APB3 slave on the MSS fabric APB bus. Consumes MSSPSEL/MSSPENABLE/MSSPWRITE/MSSPADDR/MSSPWDATA; returns PRDATA/PREADY/PSLVERR.
- Drives one GameCube controller over its single-wire open-drain line. Sends the 24-bit poll command, captures the 64-bit response and exposes it to firmware as registers plus a done interrupt.

---
 rtl/gc_apb_poller_if.sv | 21 ++
 rtl/gc_apb_poller.sv | 246 ++++++++++++++++++++++++
 tb/tb_gc_apb_poller.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/gc_apb_poller_if.sv
// APB3 bus bundle between the MSS fabric master and gc_apb_poller.
interface gc_apb_poller_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/gc_apb_poller.sv
// GameCube controller poller: APB3 register slave that sends the 24-bit poll
// command on the open-drain line and captures the 64-bit response.
// Optional macro GC_AUTOPOLL_EN adds CTRL.AUTO and a periodic internal START.
module gc_apb_poller #(
  parameter int unsigned CLK_PER_US     = 100,
  parameter int unsigned RX_TIMEOUT_US  = 200,
  parameter int unsigned POLL_PERIOD_US = 8000
) (
  input  logic           pclk,
  input  logic           preset,
  gc_apb_poller_if.slave apb,
  input  logic           gc_in,
  output logic           gc_oe,
  output logic           irq
);
  localparam int unsigned Us1    = CLK_PER_US;
  localparam int unsigned Us2    = 2 * CLK_PER_US;
  localparam int unsigned Us3    = 3 * CLK_PER_US;
  localparam int unsigned Us4    = 4 * CLK_PER_US;
  localparam int unsigned ToCyc  = RX_TIMEOUT_US * CLK_PER_US;
  localparam int unsigned CntMax = (ToCyc > Us4) ? ToCyc : Us4;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef logic [CntW-1:0] cnt_t;
  typedef enum logic [2:0] {
    StIdle, StTxLow, StTxHigh, StTxStop, StRxWait, StRxSample, StRxStop
  } state_t;

  state_t      state_q, state_d;
  cnt_t        cnt_q, cnt_d;
  logic [6:0]  bit_q, bit_d;
  logic [23:0] tx_q, tx_d;
  logic [63:0] stage_q, stage_d, data_q, data_d;
  logic        edge_q, edge_d, oe_d;
  logic        gc_s1_q, gc_s2_q, gc_prev_q, fall;
  logic        rumble_q, rumble_d, irq_en_q, irq_en_d;
  logic        done_q, done_d, timeout_q, timeout_d;
  logic        fin_done, fin_to, busy, start_req, start_go;
  logic        wr_en, mapped, ctrl_wr, stat_wr, auto_bit, auto_tick;
  logic [31:0] rdata;

  assign fall    = gc_prev_q & ~gc_s2_q;
  assign busy    = (state_q != StIdle);
  assign wr_en   = apb.psel & apb.penable & apb.pwrite;
  assign mapped  = (apb.paddr[7:4] == 4'h0);
  assign ctrl_wr = wr_en & mapped & (apb.paddr[3:2] == 2'd0);
  assign stat_wr = wr_en & mapped & (apb.paddr[3:2] == 2'd1);

`ifdef GC_AUTOPOLL_EN
  localparam int unsigned PollCyc = POLL_PERIOD_US * CLK_PER_US;
  localparam int unsigned PollW   = $clog2(PollCyc + 1);
  logic             auto_q, auto_d;
  logic [PollW-1:0] poll_q, poll_d;

  // Poll timer runs only while AUTO is set and reloads on every tick.
  always_comb begin
    auto_d    = ctrl_wr ? apb.pwdata[3] : auto_q;
    auto_tick = 1'b0;
    poll_d    = '0;
    if (auto_q) begin
      if (poll_q == PollW'(PollCyc - 1)) auto_tick = 1'b1;
      else                               poll_d    = poll_q + 1'b1;
    end
  end

  // Auto-poll state registers.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      auto_q <= 1'b0;
      poll_q <= '0;
    end else begin
      auto_q <= auto_d;
      poll_q <= poll_d;
    end
  end

  assign auto_bit = auto_q;
`else
  assign auto_bit  = 1'b0;
  assign auto_tick = 1'b0;
`endif

  assign start_req = (ctrl_wr & apb.pwdata[0]) | auto_tick;
  assign start_go  = start_req & ~busy;
  // New RUMBLE takes effect in the same write that issues START.
  assign rumble_d  = ctrl_wr ? apb.pwdata[1] : rumble_q;
  assign irq_en_d  = ctrl_wr ? apb.pwdata[2] : irq_en_q;

  // 2-flop synchronizer plus one history flop for falling-edge detection.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      gc_s1_q   <= 1'b0;
      gc_s2_q   <= 1'b0;
      gc_prev_q <= 1'b0;
    end else begin
      gc_s1_q   <= gc_in;
      gc_s2_q   <= gc_s1_q;
      gc_prev_q <= gc_s2_q;
    end
  end

  // Transfer FSM: next state, bit timer, shift registers and line drive.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + cnt_t'(1);
    bit_d    = bit_q;
    tx_d     = tx_q;
    stage_d  = stage_q;
    data_d   = data_q;
    edge_d   = edge_q;
    oe_d     = 1'b0;
    fin_done = 1'b0;
    fin_to   = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (start_go) begin
          tx_d    = {16'h4003, 7'h00, rumble_d};
          bit_d   = '0;
          state_d = StTxLow;
        end
      end
      StTxLow: begin
        oe_d = 1'b1;
        if (cnt_q == (tx_q[23] ? cnt_t'(Us1 - 1) : cnt_t'(Us3 - 1))) state_d = StTxHigh;
      end
      StTxHigh: begin
        // Timer keeps running from the low phase so each bit is exactly 4 us.
        if (cnt_q == cnt_t'(Us4 - 1)) begin
          cnt_d = '0;
          if (bit_q == 7'd23) begin
            state_d = StTxStop;
          end else begin
            bit_d   = bit_q + 7'd1;
            tx_d    = {tx_q[22:0], 1'b0};
            state_d = StTxLow;
          end
        end
      end
      StTxStop: begin
        oe_d = (cnt_q < cnt_t'(Us1));
        if (cnt_q == cnt_t'(Us4 - 1)) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = StRxWait;
        end
      end
      StRxWait: begin
        if (fall) begin
          cnt_d   = '0;
          state_d = StRxSample;
        end else if (cnt_q == cnt_t'(ToCyc - 1)) begin
          fin_to  = 1'b1;
          state_d = StIdle;
        end
      end
      StRxSample: begin
        if (cnt_q == cnt_t'(Us2 - 1)) begin
          stage_d = {stage_q[62:0], gc_s2_q};
          bit_d   = bit_q + 7'd1;
          cnt_d   = '0;
          edge_d  = 1'b0;
          state_d = (bit_q == 7'd63) ? StRxStop : StRxWait;
        end
      end
      StRxStop: begin
        if (!edge_q) begin
          if (fall) begin
            edge_d = 1'b1;
            cnt_d  = '0;
          end else if (cnt_q == cnt_t'(ToCyc - 1)) begin
            fin_to  = 1'b1;
            state_d = StIdle;
          end
        end else if (cnt_q == cnt_t'(Us2 - 1)) begin
          data_d   = stage_q;
          fin_done = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Status flags: START clears, W1C clears, FSM set wins over W1C.
  always_comb begin
    done_d    = done_q;
    timeout_d = timeout_q;
    if (start_go) begin
      done_d    = 1'b0;
      timeout_d = 1'b0;
    end
    if (stat_wr && apb.pwdata[1]) done_d    = 1'b0;
    if (stat_wr && apb.pwdata[2]) timeout_d = 1'b0;
    if (fin_done)                 done_d    = 1'b1;
    if (fin_to)                   timeout_d = 1'b1;
  end

  // All state registers; gc_oe clears asynchronously with PRESET.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_q     <= '0;
      tx_q      <= '0;
      stage_q   <= '0;
      data_q    <= '0;
      edge_q    <= 1'b0;
      gc_oe     <= 1'b0;
      rumble_q  <= 1'b0;
      irq_en_q  <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      stage_q   <= stage_d;
      data_q    <= data_d;
      edge_q    <= edge_d;
      gc_oe     <= oe_d;
      rumble_q  <= rumble_d;
      irq_en_q  <= irq_en_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  // Combinational read decode for the access phase.
  always_comb begin
    rdata = '0;
    unique case (apb.paddr[3:2])
      2'd0: rdata = {28'h0, auto_bit, irq_en_q, rumble_q, 1'b0};
      2'd1: rdata = {29'h0, timeout_q, done_q, busy};
      2'd2: rdata = data_q[63:32];
      2'd3: rdata = data_q[31:0];
      default: rdata = '0;
    endcase
  end

  assign apb.prdata  = (apb.psel & apb.penable & ~apb.pwrite & mapped) ? rdata : 32'h0;
  assign apb.pready  = 1'b1;
  assign apb.pslverr = apb.psel & apb.penable & ~mapped;
  assign irq         = done_q & irq_en_q;
endmodule

// File: tb/tb_gc_apb_poller.sv
// Directed bench for gc_apb_poller: APB register access, TX waveform decode,
// controller reply model, timeouts, partial frames and mid-transfer reset.
module tb_gc_apb_poller;
  localparam int unsigned Cpu = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic gc_oe, irq;
  logic dev_pull = 1'b0;
  wire  gc_line = ~(gc_oe | dev_pull);

  gc_apb_poller_if bus ();

  gc_apb_poller #(
    .CLK_PER_US    (Cpu),
    .RX_TIMEOUT_US (200),
    .POLL_PERIOD_US(1000)
  ) dut (
    .pclk  (clk),
    .preset(rst),
    .apb   (bus),
    .gc_in (gc_line),
    .gc_oe (gc_oe),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Low-pulse monitor on gc_oe: pulse < 2 us decodes as '1'.
  logic        mon_clr = 1'b0;
  int          tx_n, low_len, p0, p1;
  logic [24:0] tx_bits;

  always @(negedge clk) begin
    if (mon_clr) begin
      tx_n    <= 0;
      low_len <= 0;
      p0      <= 0;
      p1      <= 0;
      tx_bits <= '0;
    end else if (gc_oe) begin
      low_len <= low_len + 1;
    end else if (low_len != 0) begin
      if (tx_n == 0) p0 <= low_len;
      if (tx_n == 1) p1 <= low_len;
      tx_bits <= {tx_bits[23:0], (low_len < 2 * Cpu)};
      tx_n    <= tx_n + 1;
      low_len <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic apb_write(input logic [7:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.psel = 1'b1; bus.pwrite = 1'b1; bus.paddr = addr; bus.pwdata = data; bus.penable = 1'b0;
    @(negedge clk);
    bus.penable = 1'b1;
    @(negedge clk);
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] addr, output logic [31:0] data, output logic err);
    @(negedge clk);
    bus.psel = 1'b1; bus.pwrite = 1'b0; bus.paddr = addr; bus.penable = 1'b0;
    @(negedge clk);
    bus.penable = 1'b1;
    #1;
    data = bus.prdata;
    err  = bus.pslverr;
    @(negedge clk);
    bus.psel = 1'b0; bus.penable = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [7:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    logic        e;
    apb_read(addr, d, e);
    check(tag, d, exp);
  endtask

  task automatic clear_mon();
    @(negedge clk);
    mon_clr = 1'b1;
    @(negedge clk);
    mon_clr = 1'b0;
  endtask

  task automatic wait_tx(input int n);
    int k;
    for (k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (tx_n >= n) break;
    end
    if (k == 5000) check("wait_tx_bound", tx_n, n);
  endtask

  task automatic wait_idle();
    logic [31:0] d;
    logic        e;
    int          k;
    for (k = 0; k < 4000; k++) begin
      apb_read(8'h04, d, e);
      if (!d[0]) break;
    end
    if (k == 4000) check("wait_idle_bound", d, 32'h0);
  endtask

  // Controller model: drives nbits of d (MSB first) and an optional stop bit.
  task automatic reply(input logic [63:0] d, input int nbits, input bit stop);
    wait_tx(25);
    repeat (5 * Cpu) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      dev_pull = 1'b1;
      repeat (d[63-i] ? Cpu : 3 * Cpu) @(negedge clk);
      dev_pull = 1'b0;
      repeat (d[63-i] ? 3 * Cpu : Cpu) @(negedge clk);
    end
    if (stop) begin
      dev_pull = 1'b1;
      repeat (Cpu) @(negedge clk);
      dev_pull = 1'b0;
      repeat (3 * Cpu) @(negedge clk);
    end
  endtask

  initial begin
    logic [31:0] d;
    logic        e;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = '0; bus.pwdata = '0;
    mon_clr = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    mon_clr = 1'b0;

    // Reset state.
    read_check("rst_ctrl", 8'h00, 32'h0);
    read_check("rst_status", 8'h04, 32'h0);
    read_check("rst_data_hi", 8'h08, 32'h0);
    apb_read(8'h0C, d, e);
    check("rst_data_lo", d, 32'h0);
    check("rst_pslverr_mapped", {31'h0, e}, 32'h0);
    apb_read(8'h10, d, e);
    check("pslverr_unmapped", {31'h0, e}, 32'h1);
    check("rst_gc_oe", {31'h0, gc_oe}, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);

    // Full poll with reply, IRQ_EN set, RUMBLE clear.
    clear_mon();
    apb_write(8'h00, 32'h5);
    read_check("busy_after_start", 8'h04, 32'h1);
    reply(64'h0080_8080_8080_1F1F, 64, 1'b1);
    wait_idle();
    check("tx_bit_count", tx_n, 25);
    check("tx_pattern", {7'h0, tx_bits}, 32'h0080_0601);
    check("tx_first_low", p0, 3 * Cpu);
    check("tx_second_low", p1, Cpu);
    read_check("data_hi", 8'h08, 32'h0080_8080);
    read_check("data_lo", 8'h0C, 32'h8080_1F1F);
    read_check("status_done", 8'h04, 32'h2);
    read_check("ctrl_start_reads_0", 8'h00, 32'h4);
    check("irq_on_done", {31'h0, irq}, 32'h1);
    apb_write(8'h04, 32'h2);
    read_check("done_w1c", 8'h04, 32'h0);
    check("irq_after_w1c", {31'h0, irq}, 32'h0);
    apb_write(8'h08, 32'hFFFF_FFFF);
    read_check("ro_write_ignored", 8'h08, 32'h0080_8080);

    // No reply: timeout about 203 us after stop-bit low ends.
    clear_mon();
    apb_write(8'h00, 32'h1);
    wait_tx(25);
    repeat (1590) @(negedge clk);
    read_check("busy_before_timeout", 8'h04, 32'h1);
    repeat (60) @(negedge clk);
    read_check("timeout_set", 8'h04, 32'h4);
    read_check("timeout_data_kept", 8'h0C, 32'h8080_1F1F);
    apb_write(8'h04, 32'h4);
    read_check("timeout_w1c", 8'h04, 32'h0);

    // Partial frame (40 bits) plus a START while busy.
    clear_mon();
    apb_write(8'h00, 32'h1);
    repeat (40) @(negedge clk);
    apb_write(8'h00, 32'h1);
    reply(64'hDEAD_BEEF_0123_4567, 40, 1'b0);
    wait_idle();
    check("busy_start_bit_count", tx_n, 25);
    check("busy_start_pattern", {7'h0, tx_bits}, 32'h0080_0601);
    read_check("partial_timeout", 8'h04, 32'h4);
    read_check("partial_data_hi", 8'h08, 32'h0080_8080);
    read_check("partial_data_lo", 8'h0C, 32'h8080_1F1F);

    // Reset during TX bit 10, then a fresh poll with RUMBLE.
    clear_mon();
    apb_write(8'h00, 32'h1);
    wait_tx(10);
    for (int k = 0; k < 100; k++) begin
      if (gc_oe) break;
      @(negedge clk);
    end
    check("bit10_driving", {31'h0, gc_oe}, 32'h1);
    rst = 1'b1;
    #1;
    check("reset_oe_async", {31'h0, gc_oe}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    read_check("reset_status", 8'h04, 32'h0);
    read_check("reset_data_hi", 8'h08, 32'h0);
    clear_mon();
    apb_write(8'h00, 32'h7);
    reply(64'h1234_5678_9ABC_DEF0, 64, 1'b1);
    wait_idle();
    check("rumble_pattern", {7'h0, tx_bits}, 32'h0080_0603);
    read_check("fresh_data_hi", 8'h08, 32'h1234_5678);
    read_check("fresh_data_lo", 8'h0C, 32'h9ABC_DEF0);
    read_check("fresh_status", 8'h04, 32'h2);
    check("fresh_irq", {31'h0, irq}, 32'h1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
